uart_baud_tick_gen: RTL and testbench
=====================================

// Module: uart_baud_tick_gen
// PURPOSE
//  Parametrised UART baud tick generator, successor to the fixed 6-rate generator.
//  Emits one-cycle oversample (os_tick) and bit (bit_tick) strobes for the UART TX/RX engines.
//  Rates come from a compile-time divisor table plus one runtime custom divisor.
//  A rate change mid-bit is deferred to the next bit boundary, so no bit period is ever truncated.
// PARAMETERS
//  CLK_FREQ    100_000_000  clk frequency in Hz
//  OVERSAMPLE  16           os_ticks per bit; power of 2, range 4..64
//  DIV_W       20           divisor/counter width; must hold max table divisor
// PORTS
//  clk         in   1       system clock, all logic on rising edge
//  rst         in   1       synchronous reset, active-high
//  enable      in   1       1 = run generator; 0 = idle, counters cleared
//  sel         in   3       000 4800, 001 9600, 010 19200, 011 38400, 100 57600,
//                           101 115200, 110 custom, 111 invalid
//  custom_div  in   DIV_W   clk cycles per os_tick, used when sel=110; valid if >=2
//  os_tick     out  1       1-cycle strobe at OVERSAMPLE*baud
//  bit_tick    out  1       1-cycle strobe once per bit; coincides with the last os_tick of the bit
//  rate_upd    out  1       1-cycle strobe: a new divisor took effect
//  err         out  1       level: invalid rate selected, generator halted
// BEHAVIOUR
//  Divisor table
//   div = (CLK_FREQ + baud*OVERSAMPLE/2) / (baud*OVERSAMPLE), evaluated at elaboration.
//   Defaults give: 1302, 651, 326, 163, 109, 54.
//   sel=110 -> div = custom_div.
//   sel=111, or sel=110 with custom_div<2 -> invalid.
//  Registered state
//   act_div: active divisor. act_sel / act_cdiv: the sel / custom_div values that produced it.
//   div_cnt: 0..act_div-1.  os_cnt: 0..OVERSAMPLE-1.
//  Reset
//   rst=1 at any edge, including mid-bit -> state IDLE, all counters 0, act_div 0.
//   os_tick=bit_tick=rate_upd=err=0 from the next cycle.
//  FSM states: IDLE, RUN, FAULT
//   IDLE:
//    enable=1 & valid -> RUN: latch act_div/act_sel/act_cdiv, div_cnt=os_cnt=0, rate_upd=1.
//    enable=1 & invalid -> FAULT.
//   RUN:
//    div_cnt increments each cycle.
//    When div_cnt==act_div-1: div_cnt<=0, os_tick<=1, os_cnt increments.
//    When os_cnt==OVERSAMPLE-1 at that point: os_cnt<=0 and bit_tick<=1.
//   FAULT:
//    err=1; no ticks; counters held at 0.
//    enable=1 & valid -> RUN (same actions as IDLE->RUN), err<=0.
//  Tick timing
//   Outputs are registered.
//   First os_tick is high act_div cycles after the RUN-entry edge; the period is exactly act_div cycles.
//   The bit_tick period is exactly act_div*OVERSAMPLE cycles.
//  Rate change in RUN
//   A change is pending when (sel,custom_div) != (act_sel,act_cdiv); custom_div is compared only when sel=110.
//   The pending value is sampled on the cycle that issues bit_tick.
//   If it is valid: act_* are reloaded and rate_upd<=1 in the same cycle as bit_tick; the new period starts from div_cnt=0.
//   If it is invalid: go to FAULT; err rises the cycle after bit_tick.
//   Changes that revert before the boundary have no effect.
//  Disable
//   enable=0 in RUN or FAULT -> IDLE next edge, counters 0, err 0.
//   A tick due on that same edge is suppressed.
//  Simultaneous events
//   rst beats enable.
//   enable=0 beats a pending rate change.
//   bit_tick and rate_upd may be high together.
//  Counter rules
//   Compares are exact equality; counters never exceed act_div-1 or OVERSAMPLE-1; no wrap past the limit.
// TESTING
//  1. rst, enable=1, sel=101 -> os_tick every 54 clk, bit_tick every 864 clk on every 16th os_tick, err=0.
//  2. Running sel=001, switch to sel=100 mid-bit -> 651-cycle os period held until bit_tick;
//     rate_upd with that bit_tick; then 109-cycle period.
//  3. enable=1 sel=111 -> err=1 within 2 cycles, no ticks;
//     then sel=000 -> err=0, first os_tick 1302 cycles later.
//  4. sel=110 custom_div=1 -> err=1; custom_div=5 -> os_tick every 5 clk, bit_tick every 80 clk.
//  5. rst pulsed at div_cnt=30 of sel=101 -> all outputs 0 next cycle;
//     after release, first os_tick exactly 54 cycles after RUN entry.
//  6. enable dropped for 1 cycle in RUN -> no tick on the drop edge; counters restart, rate_upd pulses on re-entry.

Source files
------------

// File: rtl/uart_baud_tick_gen.sv
// UART baud tick generator: oversample and bit strobes from a compile-time divisor
// table plus one runtime custom divisor. Rate changes are deferred to bit boundaries.
module uart_baud_tick_gen #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int OVERSAMPLE = 16,
    parameter int DIV_W      = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [2:0]       sel,
    input  logic [DIV_W-1:0] custom_div,
    output logic             os_tick,
    output logic             bit_tick,
    output logic             rate_upd,
    output logic             err
);

    localparam int             OS_W       = $clog2(OVERSAMPLE);
    localparam int             N_RATES    = 6;
    localparam logic [2:0]     SEL_CUSTOM = 3'b110;
    localparam logic [OS_W-1:0] OS_LAST   = OS_W'(OVERSAMPLE - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FAULT
    } state_t;

    function automatic int baud_of(input int idx);
        case (idx)
            0:       return 4800;
            1:       return 9600;
            2:       return 19200;
            3:       return 38400;
            4:       return 57600;
            default: return 115200;
        endcase
    endfunction

    // Rounded clk cycles per oversample tick for a given baud rate.
    function automatic logic [DIV_W-1:0] calc_div(input int baud);
        int den;
        den = baud * OVERSAMPLE;
        return DIV_W'((CLK_FREQ + den / 2) / den);
    endfunction

    logic [DIV_W-1:0] tbl_div [N_RATES];

    genvar gi;
    generate
        for (gi = 0; gi < N_RATES; gi++) begin : g_tbl
            assign tbl_div[gi] = calc_div(baud_of(gi));
        end
    endgenerate

    state_t            state_reg, state_next;
    logic [DIV_W-1:0]  act_div_reg, act_div_next;
    logic [2:0]        act_sel_reg, act_sel_next;
    logic [DIV_W-1:0]  act_cdiv_reg, act_cdiv_next;
    logic [DIV_W-1:0]  div_cnt_reg, div_cnt_next;
    logic [OS_W-1:0]   os_cnt_reg, os_cnt_next;
    logic              os_tick_reg, os_tick_next;
    logic              bit_tick_reg, bit_tick_next;
    logic              rate_upd_reg, rate_upd_next;
    logic              err_reg, err_next;

    logic [DIV_W-1:0]  req_div;
    logic              req_valid;
    logic              pending;
    logic              div_last;
    logic              os_last;
    logic              load;

    // Requested divisor decode from the live selection inputs.
    always_comb begin
        req_div   = '0;
        req_valid = 1'b0;
        case (sel)
            3'b000: begin req_div = tbl_div[0]; req_valid = 1'b1; end
            3'b001: begin req_div = tbl_div[1]; req_valid = 1'b1; end
            3'b010: begin req_div = tbl_div[2]; req_valid = 1'b1; end
            3'b011: begin req_div = tbl_div[3]; req_valid = 1'b1; end
            3'b100: begin req_div = tbl_div[4]; req_valid = 1'b1; end
            3'b101: begin req_div = tbl_div[5]; req_valid = 1'b1; end
            3'b110: begin
                req_div   = custom_div;
                req_valid = (custom_div >= DIV_W'(2));
            end
            default: begin
                req_div   = '0;
                req_valid = 1'b0;
            end
        endcase
    end

    // custom_div only matters when the custom rate is selected.
    assign pending  = (sel != act_sel_reg) ||
                      ((sel == SEL_CUSTOM) && (custom_div != act_cdiv_reg));
    assign div_last = (div_cnt_reg == (act_div_reg - DIV_W'(1)));
    assign os_last  = (os_cnt_reg == OS_LAST);

    always_comb begin
        state_next    = state_reg;
        act_div_next  = act_div_reg;
        act_sel_next  = act_sel_reg;
        act_cdiv_next = act_cdiv_reg;
        div_cnt_next  = div_cnt_reg;
        os_cnt_next   = os_cnt_reg;
        os_tick_next  = 1'b0;
        bit_tick_next = 1'b0;
        rate_upd_next = 1'b0;
        load          = 1'b0;

        case (state_reg)
            IDLE, FAULT: begin
                div_cnt_next = '0;
                os_cnt_next  = '0;
                if (!enable) begin
                    state_next = IDLE;
                end else if (req_valid) begin
                    state_next = RUN;
                    load       = 1'b1;
                end else begin
                    state_next = FAULT;
                end
            end
            RUN: begin
                if (!enable) begin
                    // Disable wins over any tick or rate change due on this edge.
                    state_next   = IDLE;
                    div_cnt_next = '0;
                    os_cnt_next  = '0;
                end else if (div_last) begin
                    div_cnt_next = '0;
                    os_tick_next = 1'b1;
                    if (os_last) begin
                        os_cnt_next   = '0;
                        bit_tick_next = 1'b1;
                        if (pending) begin
                            if (req_valid) begin
                                load = 1'b1;
                            end else begin
                                state_next = FAULT;
                            end
                        end
                    end else begin
                        os_cnt_next = os_cnt_reg + OS_W'(1);
                    end
                end else begin
                    div_cnt_next = div_cnt_reg + DIV_W'(1);
                end
            end
            default: begin
                state_next   = IDLE;
                div_cnt_next = '0;
                os_cnt_next  = '0;
            end
        endcase

        if (load) begin
            act_div_next  = req_div;
            act_sel_next  = sel;
            act_cdiv_next = custom_div;
            div_cnt_next  = '0;
            os_cnt_next   = '0;
            rate_upd_next = 1'b1;
        end

        // err rises one cycle after FAULT entry, so it never overlaps the final bit_tick.
        err_next = (state_reg == FAULT) && (state_next == FAULT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            act_div_reg  <= '0;
            act_sel_reg  <= '0;
            act_cdiv_reg <= '0;
            div_cnt_reg  <= '0;
            os_cnt_reg   <= '0;
            os_tick_reg  <= 1'b0;
            bit_tick_reg <= 1'b0;
            rate_upd_reg <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            act_div_reg  <= act_div_next;
            act_sel_reg  <= act_sel_next;
            act_cdiv_reg <= act_cdiv_next;
            div_cnt_reg  <= div_cnt_next;
            os_cnt_reg   <= os_cnt_next;
            os_tick_reg  <= os_tick_next;
            bit_tick_reg <= bit_tick_next;
            rate_upd_reg <= rate_upd_next;
            err_reg      <= err_next;
        end
    end

    assign os_tick  = os_tick_reg;
    assign bit_tick = bit_tick_reg;
    assign rate_upd = rate_upd_reg;
    assign err      = err_reg;

endmodule

// File: tb/tb_uart_baud_tick_gen.sv
// Scoreboard bench for uart_baud_tick_gen: expected output events (edge index plus
// strobe/err values) are queued by the stimulus and popped by an independent monitor.
module tb_uart_baud_tick_gen;

    localparam int OS    = 16;
    localparam int DIV_W = 20;

    logic             clk = 1'b0;
    logic             rst;
    logic             enable;
    logic [2:0]       sel;
    logic [DIV_W-1:0] custom_div;
    logic             os_tick;
    logic             bit_tick;
    logic             rate_upd;
    logic             err;

    uart_baud_tick_gen #(
        .CLK_FREQ   (100_000_000),
        .OVERSAMPLE (OS),
        .DIV_W      (DIV_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .sel        (sel),
        .custom_div (custom_div),
        .os_tick    (os_tick),
        .bit_tick   (bit_tick),
        .rate_upd   (rate_upd),
        .err        (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        bit os;
        bit bt;
        bit ru;
        bit er;
    } ev_t;

    ev_t exp_q[$];
    int  n_checks = 0;
    int  n_pass   = 0;
    bit  mon_en   = 1'b0;
    bit  err_prev = 1'b0;

    task automatic push(input int c, input bit o, input bit b, input bit r, input bit e);
        ev_t ev;
        ev.cyc = c; ev.os = o; ev.bt = b; ev.ru = r; ev.er = e;
        exp_q.push_back(ev);
    endtask

    // os ticks k_from..k_to after a run origin; every OS-th one is also a bit tick.
    task automatic push_ticks(input int base, input int d, input int k_from, input int k_to);
        for (int k = k_from; k <= k_to; k++)
            push(base + d * k, 1'b1, (k % OS) == 0, 1'b0, 1'b0);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic start(input logic [2:0] s, input logic [DIV_W-1:0] cd, output int e);
        sel        = s;
        custom_div = cd;
        enable     = 1'b1;
        e          = cyc + 1;
    endtask

    task automatic gap();
        repeat (4) @(negedge clk);
    endtask

    task automatic check_zero(input string name);
        n_checks++;
        if ({os_tick, bit_tick, rate_upd, err} == 4'b0000)
            n_pass++;
        else
            $display("FAIL %s: outputs os/bit/upd/err=%b%b%b%b at cyc %0d, required 0000",
                     name, os_tick, bit_tick, rate_upd, err, cyc);
    endtask

    // Monitor: one event per cycle with any strobe high or an err transition.
    always @(negedge clk) begin
        if (mon_en) begin
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                ev_t m;
                m = exp_q.pop_front();
                n_checks++;
                $display("FAIL missed_event: nothing seen at cyc %0d, required os=%b bit=%b upd=%b err=%b",
                         m.cyc, m.os, m.bt, m.ru, m.er);
            end
            if (os_tick || bit_tick || rate_upd || (err != err_prev)) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL unexpected_event: os=%b bit=%b upd=%b err=%b at cyc %0d, required no event",
                             os_tick, bit_tick, rate_upd, err, cyc);
                end else begin
                    ev_t x;
                    x = exp_q.pop_front();
                    if (x.cyc == cyc && x.os == os_tick && x.bt == bit_tick &&
                        x.ru == rate_upd && x.er == err) begin
                        n_pass++;
                        $display("event cyc %0d os=%b bit=%b upd=%b err=%b ok",
                                 cyc, os_tick, bit_tick, rate_upd, err);
                    end else begin
                        $display("FAIL event: got cyc %0d os=%b bit=%b upd=%b err=%b, required cyc %0d os=%b bit=%b upd=%b err=%b",
                                 cyc, os_tick, bit_tick, rate_upd, err, x.cyc, x.os, x.bt, x.ru, x.er);
                    end
                end
            end
            err_prev = err;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish at cyc %0d, required finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int e;
        int n;
        int b;

        rst        = 1'b1;
        enable     = 1'b0;
        sel        = 3'b101;
        custom_div = '0;
        repeat (3) @(negedge clk);
        check_zero("reset_state");
        rst    = 1'b0;
        mon_en = 1'b1;
        gap();

        // 115200: 54-cycle os period, 864-cycle bit period; a reverted change is ignored.
        start(3'b101, '0, e);
        push(e, 1'b0, 1'b0, 1'b1, 1'b0);
        push_ticks(e, 54, 1, 32);
        wait_until(e + 100);  sel = 3'b000;
        wait_until(e + 200);  sel = 3'b101;
        wait_until(e + 32 * 54);
        enable = 1'b0;
        gap();

        // 9600 -> 57600 mid-bit: switch lands on the bit_tick together with rate_upd.
        start(3'b001, '0, e);
        b = e + OS * 651;
        push(e, 1'b0, 1'b0, 1'b1, 1'b0);
        push_ticks(e, 651, 1, OS - 1);
        push(b, 1'b1, 1'b1, 1'b1, 1'b0);
        push_ticks(b, 109, 1, OS);
        wait_until(e + 5 * 651 + 100);
        sel = 3'b100;
        wait_until(b + OS * 109);
        enable = 1'b0;
        gap();

        // Invalid select faults; a valid table rate recovers with a full 1302-cycle period.
        start(3'b111, '0, e);
        n = e - 1;
        push(n + 2, 1'b0, 1'b0, 1'b0, 1'b1);
        wait_until(n + 20);
        sel = 3'b000;
        push(n + 21, 1'b0, 1'b0, 1'b1, 1'b0);
        push(n + 21 + 1302, 1'b1, 1'b0, 1'b0, 1'b0);
        wait_until(n + 21 + 1302);
        enable = 1'b0;
        gap();

        // Custom divisor 1 is invalid; 5 runs; then an invalid change faults at the bit boundary.
        start(3'b110, DIV_W'(1), e);
        n = e - 1;
        push(n + 2, 1'b0, 1'b0, 1'b0, 1'b1);
        wait_until(n + 10);
        custom_div = DIV_W'(5);
        e = n + 11;
        push(e, 1'b0, 1'b0, 1'b1, 1'b0);
        push_ticks(e, 5, 1, 48);
        push(e + 241, 1'b0, 1'b0, 1'b0, 1'b1);
        push(e + 246, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_until(e + 170);
        sel = 3'b111;
        wait_until(e + 245);
        enable = 1'b0;
        gap();

        // Smallest legal custom divisor.
        start(3'b110, DIV_W'(2), e);
        push(e, 1'b0, 1'b0, 1'b1, 1'b0);
        push_ticks(e, 2, 1, OS);
        wait_until(e + 2 * OS);
        enable = 1'b0;
        gap();

        // Reset pulse mid-bit at div_cnt=30, then a clean restart.
        start(3'b101, '0, e);
        push(e, 1'b0, 1'b0, 1'b1, 1'b0);
        wait_until(e + 30);
        rst = 1'b1;
        @(negedge clk);
        check_zero("reset_mid_bit");
        rst = 1'b0;
        push(e + 32, 1'b0, 1'b0, 1'b1, 1'b0);
        push_ticks(e + 32, 54, 1, OS);
        wait_until(e + 32 + OS * 54);
        enable = 1'b0;
        gap();

        // One-cycle enable drop on the edge where the 4th os_tick was due.
        start(3'b101, '0, e);
        push(e, 1'b0, 1'b0, 1'b1, 1'b0);
        push_ticks(e, 54, 1, 3);
        wait_until(e + 215);
        enable = 1'b0;
        wait_until(e + 216);
        enable = 1'b1;
        push(e + 217, 1'b0, 1'b0, 1'b1, 1'b0);
        push_ticks(e + 217, 54, 1, OS);
        wait_until(e + 217 + OS * 54);
        enable = 1'b0;

        repeat (10) @(negedge clk);
        n_checks++;
        if (exp_q.size() == 0)
            n_pass++;
        else
            $display("FAIL queue_drain: %0d events outstanding, required 0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
